// File: rtl/interleaver_ctrl_if.sv
// Byte stream, RAM-stage and output signals of the convolutional interleaver controller.
// The design drives the slave side; the source and the RAM stage drive the master side.
interface interleaver_ctrl_if;
    logic        in_valid;
    logic        in_sync;
    logic [7:0]  din;
    logic [7:0]  ram_dout;
    logic [10:0] push;
    logic [3:0]  sel;
    logic        ram_re;
    logic [7:0]  ram_din;
    logic        out_valid;
    logic        out_sync;
    logic [7:0]  dout;
    logic        sync_err;

    modport slave (
        input  in_valid, in_sync, din, ram_dout,
        output push, sel, ram_re, ram_din, out_valid, out_sync, dout, sync_err
    );

    modport master (
        output in_valid, in_sync, din, ram_dout,
        input  push, sel, ram_re, ram_din, out_valid, out_sync, dout, sync_err
    );
endinterface

// File: rtl/interleaver_ctrl.sv
// Convolutional interleaver controller: steers bytes round-robin onto RAM delay levels,
// bypasses branch 0 through two registers so every branch shows a 2-cycle latency.
module interleaver_ctrl #(
    parameter int unsigned SYNC_ALIGN = 1,
    parameter int unsigned NBR        = 12
) (
    input logic              clk,
    input logic              reset,
    interleaver_ctrl_if.slave bus
);

    logic [3:0]  br_q;
    logic [3:0]  cur_br;
    logic [3:0]  nxt_br;
    logic [3:0]  lvl;

    logic [10:0] push_q;
    logic [3:0]  sel_q;
    logic        ram_re_q;
    logic [7:0]  ram_din_q;
    logic        sync_err_q;

    logic        s1_valid_q;
    logic        s1_sync_q;
    logic        s1_byp_q;
    logic [7:0]  byp1_q;

    logic        out_valid_q;
    logic        out_sync_q;
    logic        out_byp_q;
    logic [7:0]  byp2_q;
    logic [7:0]  hold_q;
    logic [7:0]  dout_c;

    always_comb begin
        cur_br = br_q;
        if ((SYNC_ALIGN != 0) && bus.in_sync) begin
            cur_br = 4'd0;
        end
        nxt_br = (cur_br == 4'(NBR - 1)) ? 4'd0 : cur_br + 4'd1;
        lvl    = cur_br - 4'd1;
    end

    // RAM read data arrives in the output cycle itself, so the output mux is combinational;
    // hold_q keeps the last valid byte visible across idle cycles.
    always_comb begin
        dout_c = hold_q;
        if (out_valid_q) begin
            dout_c = out_byp_q ? byp2_q : bus.ram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_q        <= '0;
            push_q      <= '0;
            sel_q       <= '0;
            ram_re_q    <= 1'b0;
            ram_din_q   <= '0;
            sync_err_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sync_q   <= 1'b0;
            s1_byp_q    <= 1'b0;
            byp1_q      <= '0;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
            out_byp_q   <= 1'b0;
            byp2_q      <= '0;
            hold_q      <= '0;
        end else begin
            push_q     <= '0;
            ram_re_q   <= 1'b0;
            s1_valid_q <= bus.in_valid;
            s1_sync_q  <= bus.in_valid & bus.in_sync;
            if (bus.in_valid) begin
                br_q     <= nxt_br;
                s1_byp_q <= (cur_br == 4'd0);
                byp1_q   <= bus.din;
                if (cur_br != 4'd0) begin
                    push_q    <= 11'd1 << lvl;
                    sel_q     <= lvl;
                    ram_re_q  <= 1'b1;
                    ram_din_q <= bus.din;
                end
                if (bus.in_sync && (br_q != 4'd0)) begin
                    sync_err_q <= 1'b1;
                end
            end

            out_valid_q <= s1_valid_q;
            out_sync_q  <= s1_sync_q;
            if (s1_valid_q) begin
                out_byp_q <= s1_byp_q;
                byp2_q    <= byp1_q;
            end
            if (out_valid_q) begin
                hold_q <= dout_c;
            end
        end
    end

    assign bus.push      = push_q;
    assign bus.sel       = sel_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sync  = out_sync_q;
    assign bus.dout      = dout_c;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Directed table-driven bench for interleaver_ctrl with a delay-line RAM model on the RAM port,
// followed by a random stream checked against a bench-side branch model.
module tb_interleaver_ctrl;

    logic clk;
    logic reset;

    interleaver_ctrl_if bus ();

    interleaver_ctrl #(
        .SYNC_ALIGN (1),
        .NBR        (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream RAM: level l is a delay line of l+1 bytes, read-before-write on ram_re.
    logic [7:0] mem [0:10][0:10];
    int         ptr [0:10];

    initial begin
        for (int l = 0; l < 11; l++) begin
            ptr[l] = 0;
            for (int j = 0; j < 11; j++) mem[l][j] = 8'h00;
        end
        bus.ram_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.ram_re && (bus.sel < 4'd11)) begin
            bus.ram_dout               <= mem[bus.sel][ptr[bus.sel]];
            mem[bus.sel][ptr[bus.sel]] <= bus.ram_din;
            ptr[bus.sel]               <= (ptr[bus.sel] == int'(bus.sel)) ? 0 : ptr[bus.sel] + 1;
        end
    end

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        int          br;
        logic [10:0] push;
        logic        err;
    } vec_t;

    vec_t ta [12];
    vec_t tb_ [21];

    int n_chk  = 0;
    int n_pass = 0;
    int step_no = 0;

    // Expected-state tracking for held outputs and the stage-2 view of the previous byte.
    logic [3:0] exp_sel  = 4'd0;
    logic [7:0] exp_rdin = 8'h00;
    logic [7:0] exp_dout = 8'h00;
    logic       pv = 1'b0;
    logic       ps = 1'b0;
    int         pbr = -1;
    logic [7:0] pd = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] d, input int br,
                        input logic [10:0] xpush, input logic xerr);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.din      = d;
        @(posedge clk);
        #1;
        step_no++;
        if (v && br > 0) begin
            exp_sel  = 4'(br - 1);
            exp_rdin = d;
        end
        chk("push", 32'(bus.push), 32'(xpush));
        chk("ram_re", 32'(bus.ram_re), 32'(v && br > 0));
        chk("sel", 32'(bus.sel), 32'(exp_sel));
        chk("ram_din", 32'(bus.ram_din), 32'(exp_rdin));
        chk("sync_err", 32'(bus.sync_err), 32'(xerr));
        chk("out_valid", 32'(bus.out_valid), 32'(pv));
        if (pv) begin
            exp_dout = (pbr == 0) ? pd : bus.ram_dout;
            chk("out_sync", 32'(bus.out_sync), 32'(ps));
        end
        chk("dout", 32'(bus.dout), 32'(exp_dout));
        pv  = v;
        ps  = v & s;
        pbr = br;
        pd  = d;
    endtask

    task automatic do_reset(input logic v, input int cycles);
        reset        = 1'b1;
        bus.in_valid = v;
        bus.in_sync  = 1'b0;
        bus.din      = 8'hA5;
        for (int i = 0; i < cycles; i++) @(posedge clk);
        #1;
        step_no++;
        chk("rst push", 32'(bus.push), 32'd0);
        chk("rst sel", 32'(bus.sel), 32'd0);
        chk("rst ram_re", 32'(bus.ram_re), 32'd0);
        chk("rst ram_din", 32'(bus.ram_din), 32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_sync", 32'(bus.out_sync), 32'd0);
        chk("rst dout", 32'(bus.dout), 32'd0);
        chk("rst sync_err", 32'(bus.sync_err), 32'd0);
        reset    = 1'b0;
        exp_sel  = 4'd0;
        exp_rdin = 8'h00;
        exp_dout = 8'h00;
        pv       = 1'b0;
    endtask

    initial begin
        int          br_m;
        logic        err_m;
        int          b;
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [10:0] xp;

        // One full branch cycle after sync.
        ta[0]  = '{1'b1, 1'b1, 8'h00, 0,  11'h000, 1'b0};
        ta[1]  = '{1'b1, 1'b0, 8'h01, 1,  11'h001, 1'b0};
        ta[2]  = '{1'b1, 1'b0, 8'h02, 2,  11'h002, 1'b0};
        ta[3]  = '{1'b1, 1'b0, 8'h03, 3,  11'h004, 1'b0};
        ta[4]  = '{1'b1, 1'b0, 8'h04, 4,  11'h008, 1'b0};
        ta[5]  = '{1'b1, 1'b0, 8'h05, 5,  11'h010, 1'b0};
        ta[6]  = '{1'b1, 1'b0, 8'h06, 6,  11'h020, 1'b0};
        ta[7]  = '{1'b1, 1'b0, 8'h07, 7,  11'h040, 1'b0};
        ta[8]  = '{1'b1, 1'b0, 8'h08, 8,  11'h080, 1'b0};
        ta[9]  = '{1'b1, 1'b0, 8'h09, 9,  11'h100, 1'b0};
        ta[10] = '{1'b1, 1'b0, 8'h0A, 10, 11'h200, 1'b0};
        ta[11] = '{1'b1, 1'b0, 8'h0B, 11, 11'h400, 1'b0};

        // Gapped input (1 on, 2 off), then a misplaced sync at branch 5.
        tb_[0]  = '{1'b1, 1'b0, 8'h30, 0,  11'h000, 1'b0};
        tb_[1]  = '{1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b0};
        tb_[2]  = '{1'b0, 1'b1, 8'hFF, -1, 11'h000, 1'b0};
        tb_[3]  = '{1'b1, 1'b0, 8'h31, 1,  11'h001, 1'b0};
        tb_[4]  = '{1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b0};
        tb_[5]  = '{1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b0};
        tb_[6]  = '{1'b1, 1'b0, 8'h32, 2,  11'h002, 1'b0};
        tb_[7]  = '{1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b0};
        tb_[8]  = '{1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b0};
        tb_[9]  = '{1'b1, 1'b0, 8'h33, 3,  11'h004, 1'b0};
        tb_[10] = '{1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b0};
        tb_[11] = '{1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b0};
        tb_[12] = '{1'b1, 1'b0, 8'h40, 4,  11'h008, 1'b0};
        tb_[13] = '{1'b1, 1'b1, 8'h41, 0,  11'h000, 1'b1};
        tb_[14] = '{1'b1, 1'b0, 8'h42, 1,  11'h001, 1'b1};
        tb_[15] = '{1'b1, 1'b0, 8'h43, 2,  11'h002, 1'b1};
        tb_[16] = '{1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b1};
        tb_[17] = '{1'b1, 1'b0, 8'h44, 3,  11'h004, 1'b1};
        tb_[18] = '{1'b1, 1'b0, 8'h45, 4,  11'h008, 1'b1};
        tb_[19] = '{1'b1, 1'b0, 8'h46, 5,  11'h010, 1'b1};
        tb_[20] = '{1'b1, 1'b0, 8'h47, 6,  11'h020, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.din      = 8'h00;
        do_reset(1'b0, 2);

        // Two passes give 24 consecutive bytes; the 13th wraps back to branch 0.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 12; i++) begin
                step(ta[i].v, ta[i].s & (p == 0), ta[i].d + 8'(12 * p), ta[i].br, ta[i].push,
                     ta[i].err);
            end
        end

        for (int i = 0; i < 21; i++) begin
            step(tb_[i].v, tb_[i].s, tb_[i].d, tb_[i].br, tb_[i].push, tb_[i].err);
        end

        // Byte at branch 7 presented together with reset, earlier bytes still in flight.
        do_reset(1'b1, 1);
        step(1'b1, 1'b0, 8'h50, 0, 11'h000, 1'b0);
        step(1'b1, 1'b0, 8'h51, 1, 11'h001, 1'b0);
        step(1'b0, 1'b0, 8'h00, -1, 11'h000, 1'b0);

        br_m  = 2;
        err_m = 1'b0;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 15) == 0);
            d = 8'($urandom);
            b  = -1;
            xp = 11'h000;
            if (v) begin
                b = s ? 0 : br_m;
                if (s && br_m != 0) err_m = 1'b1;
                br_m = (b == 11) ? 0 : b + 1;
                if (b != 0) xp = 11'd1 << (b - 1);
            end
            step(v, s, d, b, xp, err_m);
            chk("push onehot", 32'($countones(bus.push) <= 1), 32'd1);
            chk("push implies re", 32'((bus.push == 11'h000) || bus.ram_re), 32'd1);
        end
        step(1'b0, 1'b0, 8'h00, -1, 11'h000, err_m);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
